sipo_rx: RTL and testbench

//   Serial-in parallel-out receiver. Pairs with the team's parallel-in serial-out

---
 rtl/sipo_rx.sv | 95 +++++++++
 tb/tb_sipo_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
// Serial-in parallel-out receiver: rebuilds WIDTH-bit words LSB-first from a
// strobed serial stream and offers each word on a registered valid/ready port.
module sipo_rx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             srl_i,
  input  logic             vld_i,
  input  logic             sync_i,
  output logic [WIDTH-1:0] prl_o,
  output logic             prl_vld_o,
  input  logic             prl_rdy_i,
  output logic             busy_o,
  output logic             ovf_o,
  input  logic             clr_ovf_i
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] r_prl;
  logic             r_vld;
  logic             r_busy;
  logic             r_ovf;

  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_complete;
  logic             w_accept;
  logic             w_overrun;

  // A sync bit always starts a new word, so it can never complete one (WIDTH >= 2).
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_complete = vld_i & ~sync_i & w_last;
  assign w_word     = {srl_i, r_shift[WIDTH-2:0]};
  assign w_accept   = ~r_vld | prl_rdy_i;
  assign w_overrun  = w_complete & ~w_accept;

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    if (sync_i) begin
      w_shift_nxt = '0;
      if (vld_i) begin
        w_shift_nxt[0] = srl_i;
        w_cnt_nxt      = CNT_W'(1);
      end else begin
        w_cnt_nxt = '0;
      end
    end else if (vld_i) begin
      if (w_last) begin
        w_cnt_nxt   = '0;
        w_shift_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
          if (r_cnt == CNT_W'(i)) w_shift_nxt[i] = srl_i;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_prl   <= '0;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_busy  <= (w_cnt_nxt != '0);
      // A transfer and a completion on the same edge hand straight over to the new word.
      if (w_complete && w_accept) begin
        r_prl <= w_word;
        r_vld <= 1'b1;
      end else if (r_vld && prl_rdy_i) begin
        r_vld <= 1'b0;
      end
      if (w_overrun)      r_ovf <= 1'b1;
      else if (clr_ovf_i) r_ovf <= 1'b0;
    end
  end

  assign prl_o     = r_prl;
  assign prl_vld_o = r_vld;
  assign busy_o    = r_busy;
  assign ovf_o     = r_ovf;

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the receiver.
module tb_sipo_rx;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             srl_i = 1'b0;
  logic             vld_i = 1'b0;
  logic             sync_i = 1'b0;
  logic             prl_rdy_i = 1'b0;
  logic             clr_ovf_i = 1'b0;
  logic [WIDTH-1:0] prl_o;
  logic             prl_vld_o;
  logic             busy_o;
  logic             ovf_o;

  int n_tests = 0;
  int n_fail  = 0;

  bit         m_bits[$];
  int         m_prl;
  bit         m_vld;
  bit         m_ovf;

  sipo_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .srl_i     (srl_i),
    .vld_i     (vld_i),
    .sync_i    (sync_i),
    .prl_o     (prl_o),
    .prl_vld_o (prl_vld_o),
    .prl_rdy_i (prl_rdy_i),
    .busy_o    (busy_o),
    .ovf_o     (ovf_o),
    .clr_ovf_i (clr_ovf_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: bits of the open word live in a queue; a full queue is a word.
  task automatic model_step();
    bit done;
    int word;
    bit overrun;
    done = 0;
    word = 0;
    overrun = 0;
    if (sync_i) m_bits.delete();
    if (vld_i) begin
      m_bits.push_back(srl_i);
      if (m_bits.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) word += int'(m_bits[i]) * (1 << i);
        m_bits.delete();
        done = 1;
      end
    end
    if (done) begin
      if (!m_vld || prl_rdy_i) begin
        m_prl = word;
        m_vld = 1;
      end else begin
        overrun = 1;
      end
    end else if (m_vld && prl_rdy_i) begin
      m_vld = 0;
    end
    if (overrun) m_ovf = 1;
    else if (clr_ovf_i) m_ovf = 0;
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_prl = 0;
    m_vld = 0;
    m_ovf = 0;
  endtask

  task automatic cyc(input bit s, input bit v, input bit y, input bit r, input bit c);
    srl_i     = s;
    vld_i     = v;
    sync_i    = y;
    prl_rdy_i = r;
    clr_ovf_i = c;
    model_step();
    @(posedge clk);
    #1;
    chk("prl", prl_o, m_prl);
    chk("prl_vld", prl_vld_o, m_vld);
    chk("busy", busy_o, m_bits.size() != 0);
    chk("ovf", ovf_o, m_ovf);
  endtask

  task automatic idle(input bit r);
    cyc(0, 0, 0, r, 0);
  endtask

  task automatic send_word(input int word, input bit r, input int gap_max);
    for (int i = 0; i < WIDTH; i++) begin
      if (gap_max > 0) begin
        int g;
        g = $urandom_range(gap_max, 0);
        for (int k = 0; k < g; k++) idle(r);
      end
      cyc(((word >> i) & 1) != 0, 1, 0, r, 0);
    end
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    chk({tag, "_prl"}, prl_o, 0);
    chk({tag, "_vld"}, prl_vld_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ovf"}, ovf_o, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    #7;
    do_reset("rst0");

    // 1: back-to-back bits 1,0,1,1
    cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    chk("t1_word", prl_o, 4'hD);
    chk("t1_vld", prl_vld_o, 1);
    idle(1);
    chk("t1_vld_drop", prl_vld_o, 0);

    // 2: same word with gaps
    cyc(1, 1, 0, 1, 0);
    chk("t2_busy", busy_o, 1);
    idle(1);
    idle(1);
    cyc(0, 1, 0, 1, 0);
    idle(1);
    cyc(1, 1, 0, 1, 0);
    idle(1);
    idle(1);
    idle(1);
    chk("t2_busy_mid", busy_o, 1);
    cyc(1, 1, 0, 1, 0);
    chk("t2_word", prl_o, 4'hD);
    chk("t2_busy_end", busy_o, 0);
    idle(1);

    // 3: back-to-back words
    send_word(4'h3, 1, 0);
    chk("t3_w0", prl_o, 4'h3);
    send_word(4'hA, 1, 0);
    chk("t3_w1", prl_o, 4'hA);
    chk("t3_ovf", ovf_o, 0);
    idle(1);

    // 4: overrun
    send_word(4'h5, 0, 0);
    send_word(4'h6, 0, 0);
    chk("t4_hold", prl_o, 4'h5);
    chk("t4_ovf", ovf_o, 1);
    idle(1);
    chk("t4_taken", prl_vld_o, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_clr", ovf_o, 0);

    // 5: sync discards partial word
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(0, 1, 1, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    chk("t5_word", prl_o, 4'hE);
    idle(1);

    // 6: reset mid-word and mid-handshake
    cyc(1, 1, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    do_reset("t6a");
    send_word(4'h9, 1, 0);
    chk("t6a_word", prl_o, 4'h9);
    idle(0);
    send_word(4'h7, 0, 0);
    do_reset("t6b");
    send_word(4'hC, 1, 0);
    chk("t6b_word", prl_o, 4'hC);
    idle(1);

    // set and clear in the same cycle: set wins
    send_word(4'h1, 0, 0);
    for (int i = 0; i < WIDTH - 1; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 1);
    chk("set_wins", ovf_o, 1);
    cyc(0, 0, 0, 1, 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(1, 0) == 1,
          $urandom_range(9, 0) < 7,
          $urandom_range(19, 0) == 0,
          $urandom_range(9, 0) < 6,
          $urandom_range(9, 0) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
